// File: rtl/wb_matrix_engine_if.sv
// wb_matrix_engine_if: Wishbone classic bus bundle between a master and the matrix engine
interface wb_matrix_engine_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] addr;
  logic [31:0] dat_w;
  logic        ack;
  logic [31:0] dat_r;
  modport master(output cyc, stb, we, addr, dat_w, input ack, dat_r);
  modport slave(input cyc, stb, we, addr, dat_w, output ack, dat_r);
endinterface

// File: rtl/wb_matrix_engine.sv
// wb_matrix_engine: Wishbone-slave matrix coprocessor (MUL/ADD/RELU) with one MAC per cycle
module wb_matrix_engine #(
  parameter logic [31:0] ADDR_OFFSET = 32'h3010_0000,
  parameter int          DATA_W      = 32,
  parameter int          MAX_DIM     = 4
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  wb_matrix_engine_if.slave wb,
  output logic              irq_o
);
  localparam int D2 = MAX_DIM * MAX_DIM;
  localparam int IW = (D2 > 1) ? $clog2(D2) : 1;
  localparam int ACC_W = 2 * DATA_W + $clog2(MAX_DIM);
  localparam logic [31:0] A0 = 32'(16);
  localparam logic [31:0] B0 = 32'(16 + D2);
  localparam logic [31:0] C0 = 32'(16 + 2 * D2);
  localparam logic [31:0] NW = 32'(16 + 3 * D2);
  localparam logic [7:0] MD = 8'(MAX_DIM);

  typedef enum logic [1:0] {IDLE, CHECK, RUN, DONE} state_t;
  state_t state_q, state_d;

  logic [DATA_W-1:0] a_q [D2];
  logic [DATA_W-1:0] b_q [D2];
  logic [DATA_W-1:0] c_q [D2];
  logic [2:0] op_q;
  logic irq_en_q, done_q, err_q, ack_q, held_q;
  logic [7:0] m_q, k_q, n_q, i_q, j_q, kk_q;
  logic [31:0] cycles_q, rdata_q, off, w, rd;
  logic signed [ACC_W-1:0] acc_q, prod;
  logic signed [DATA_W-1:0] mul_a, mul_b;
  logic [DATA_W-1:0] ea_v, eb_v, ew;
  logic mapped, in_a, in_b, in_c, req, wr_ok, start, busy, is_mul, chk_err;
  logic last_col, last_row, run_last;
  logic [IW-1:0] ea, eb, ec;
  logic unused_bits;

  function automatic logic [IW-1:0] ix(input logic [7:0] r, input logic [7:0] c);
    return IW'(32'(r) * MAX_DIM + 32'(c));
  endfunction

  assign off = wb.addr - ADDR_OFFSET;
  assign w = {2'b00, off[31:2]};
  assign unused_bits = ^off[1:0];
  assign mapped = (wb.addr >= ADDR_OFFSET) && (w < NW);
  assign in_a = mapped && w >= A0 && w < B0;
  assign in_b = mapped && w >= B0 && w < C0;
  assign in_c = mapped && w >= C0;
  assign ea = IW'(w - A0);
  assign eb = IW'(w - B0);
  assign ec = IW'(w - C0);
  // held_q blocks a strobe kept high past its ack from being serviced again
  assign req = wb.cyc & wb.stb & ~ack_q & ~held_q;
  assign busy = state_q != IDLE;
  assign wr_ok = req & wb.we & mapped & ~busy;
  assign start = wr_ok && w == 32'd0 && wb.dat_w[0];
  assign is_mul = op_q == 3'd1;
  assign chk_err = m_q == 8'd0 || m_q > MD || k_q == 8'd0 || k_q > MD ||
                   (is_mul && (n_q == 8'd0 || n_q > MD)) || op_q == 3'd0 || op_q > 3'd3;
  assign last_col = j_q == (is_mul ? n_q : k_q) - 8'd1;
  assign last_row = i_q == m_q - 8'd1;
  assign run_last = last_col && last_row && (!is_mul || kk_q == k_q);
  assign mul_a = a_q[ix(i_q, kk_q)];
  assign mul_b = b_q[ix(kk_q, j_q)];
  assign prod = ACC_W'(mul_a) * ACC_W'(mul_b);
  assign ea_v = a_q[ix(i_q, j_q)];
  assign eb_v = b_q[ix(i_q, j_q)];
  assign ew = op_q == 3'd2 ? ea_v + eb_v : (ea_v[DATA_W-1] ? '0 : ea_v);
  assign irq_o = irq_en_q & (done_q | err_q);
  assign wb.ack = ack_q;
  assign wb.dat_r = rdata_q;

  always_comb begin
    rd = !mapped     ? 32'd0 :
         w == 32'd0  ? {27'b0, irq_en_q, op_q, 1'b0} :
         w == 32'd1  ? {29'b0, err_q, done_q, busy} :
         w == 32'd2  ? {8'b0, n_q, k_q, m_q} :
         w == 32'd3  ? cycles_q :
         in_a        ? 32'(a_q[ea]) :
         in_b        ? 32'(b_q[eb]) :
         in_c        ? 32'(c_q[ec]) : 32'd0;
  end

  always_comb begin
    state_d = state_q == IDLE  ? (start ? CHECK : IDLE) :
              state_q == CHECK ? (chk_err ? IDLE : RUN) :
              state_q == RUN   ? (run_last ? DONE : RUN) : IDLE;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      ack_q    <= 1'b0;
      held_q   <= 1'b0;
      rdata_q  <= '0;
      op_q     <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      m_q      <= '0;
      k_q      <= '0;
      n_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      kk_q     <= '0;
      cycles_q <= '0;
      acc_q    <= '0;
      for (int x = 0; x < D2; x++) begin
        a_q[x] <= '0;
        b_q[x] <= '0;
        c_q[x] <= '0;
      end
    end else begin
      state_q <= state_d;
      ack_q   <= req;
      held_q  <= wb.cyc & wb.stb & (ack_q | held_q);
      rdata_q <= (req && !wb.we) ? rd : '0;
      if (wr_ok && w == 32'd0) begin
        op_q     <= wb.dat_w[3:1];
        irq_en_q <= wb.dat_w[4];
      end
      if (start) begin
        done_q   <= 1'b0;
        err_q    <= 1'b0;
        cycles_q <= '0;
      end
      if (wr_ok && w == 32'd2) {n_q, k_q, m_q} <= wb.dat_w[23:0];
      if (wr_ok && in_a) a_q[ea] <= wb.dat_w[DATA_W-1:0];
      if (wr_ok && in_b) b_q[eb] <= wb.dat_w[DATA_W-1:0];
      if (state_q == CHECK) begin
        i_q   <= '0;
        j_q   <= '0;
        kk_q  <= '0;
        acc_q <= '0;
        err_q <= chk_err;
      end
      if (state_q == RUN) begin
        cycles_q <= &cycles_q ? cycles_q : cycles_q + 32'd1;
        if (is_mul && kk_q != k_q) begin
          acc_q <= acc_q + prod;
          kk_q  <= kk_q + 8'd1;
        end else begin
          c_q[ix(i_q, j_q)] <= is_mul ? acc_q[DATA_W-1:0] : ew;
          acc_q <= '0;
          kk_q  <= '0;
          j_q   <= last_col ? 8'd0 : j_q + 8'd1;
          i_q   <= last_col ? i_q + 8'd1 : i_q;
        end
      end
      if (state_q == DONE) done_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_matrix_engine.sv
// tb_wb_matrix_engine: directed bench with a read scoreboard for the Wishbone matrix engine
module tb_wb_matrix_engine;
  localparam logic [31:0] OFF = 32'h3010_0000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;
  int n_asrt = 0;
  int n_fail = 0;
  typedef struct { string tag; logic [31:0] exp; } exp_t;
  exp_t sb[$];

  wb_matrix_engine_if bus();
  wb_matrix_engine dut (.wb_clk_i(clk), .wb_rst_i(rst), .wb(bus), .irq_o(irq));

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] el(int base, int r, int c);
    return OFF + 32'(4 * (16 + base * 16 + r * 4 + c));
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] data,
                      output logic [31:0] rdata, output logic ok);
    int n;
    n = 0;
    @(posedge clk); #1;
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = we; bus.addr = addr; bus.dat_w = data;
    do begin
      @(posedge clk); #1;
      n++;
    end while (bus.ack !== 1'b1 && n < 8);
    ok = bus.ack;
    rdata = bus.dat_r;
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] d;
    logic ok;
    xfer(1'b1, addr, data, d, ok);
    chk("wr_ack", 32'(ok), 32'd1);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic ok;
    exp_t e;
    sb.push_back('{tag, exp});
    xfer(1'b0, addr, 32'd0, d, ok);
    e = sb.pop_front();
    chk({e.tag, "_ack"}, 32'(ok), 32'd1);
    chk(e.tag, d, e.exp);
  endtask

  task automatic wait_done();
    logic [31:0] s;
    logic ok;
    int n;
    s = 32'd1;
    n = 0;
    while (s[0] && n < 40) begin
      xfer(1'b0, OFF + 32'd4, 32'd0, s, ok);
      n++;
    end
    chk("wait_busy", 32'(s[0]), 32'd0);
  endtask

  task automatic load_mul();
    logic [31:0] am[4] = '{32'd1, 32'd2, 32'd3, 32'd4};
    logic [31:0] bm[4] = '{32'd5, 32'd6, 32'd7, 32'd8};
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        wr(el(0, r, c), am[r * 2 + c]);
        wr(el(1, r, c), bm[r * 2 + c]);
      end
    wr(OFF + 32'd8, 32'h0002_0202);
  endtask

  task automatic check_mul(string pfx);
    logic [31:0] cm[4] = '{32'd19, 32'd22, 32'd43, 32'd50};
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        rd_chk($sformatf("%s_c%0d%0d", pfx, r, c), el(2, r, c), cm[r * 2 + c]);
    rd_chk({pfx, "_status"}, OFF + 32'd4, 32'd2);
    rd_chk({pfx, "_cycles"}, OFF + 32'd12, 32'd12);
  endtask

  initial begin
    int acks;
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.dat_w = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_dat", bus.dat_r, 32'd0);
    rst = 1'b0;
    rd_chk("status0", OFF + 32'd4, 32'd0);
    rd_chk("w20", OFF + 32'h50, 32'd0);
    wr(32'h3000_0000, 32'hDEAD_BEEF);
    wr(OFF + 32'd256, 32'h1234_5678);
    rd_chk("unmapped_hi", OFF + 32'd256, 32'd0);
    rd_chk("a00_after_unmapped", el(0, 0, 0), 32'd0);
    rd_chk("ctrl_after_unmapped", OFF, 32'd0);

    load_mul();
    wr(OFF, 32'h0000_0003);
    rd_chk("mul_busy", OFF + 32'd4, 32'd1);
    wait_done();
    check_mul("mul");
    rd_chk("mul_c02_kept", el(2, 0, 2), 32'd0);
    rd_chk("ctrl_rd", OFF, 32'd2);
    chk("mul_irq_off", 32'(irq), 32'd0);

    wr(el(0, 0, 0), 32'hFFFF_FFFF); wr(el(0, 0, 1), 32'd5); wr(el(0, 0, 2), 32'h7FFF_FFFF);
    for (int c = 0; c < 3; c++) wr(el(1, 0, c), 32'd1);
    wr(OFF + 32'd8, 32'h0000_0301);
    wr(OFF, 32'h0000_0005);
    wait_done();
    rd_chk("add_c00", el(2, 0, 0), 32'd0);
    rd_chk("add_c01", el(2, 0, 1), 32'd6);
    rd_chk("add_c02", el(2, 0, 2), 32'h8000_0000);
    rd_chk("add_c10_kept", el(2, 1, 0), 32'd43);
    rd_chk("add_cycles", OFF + 32'd12, 32'd3);

    wr(el(0, 0, 0), 32'hFFFF_FFFD); wr(el(0, 0, 1), 32'd4); wr(el(0, 0, 2), 32'd0);
    wr(OFF, 32'h0000_0007);
    wait_done();
    rd_chk("relu_c00", el(2, 0, 0), 32'd0);
    rd_chk("relu_c01", el(2, 0, 1), 32'd4);
    rd_chk("relu_c02", el(2, 0, 2), 32'd0);
    rd_chk("relu_c11_kept", el(2, 1, 1), 32'd50);

    wr(OFF + 32'd8, 32'h0002_0205);
    wr(OFF, 32'h0000_0013);
    rd_chk("dim_err_status", OFF + 32'd4, 32'd4);
    chk("dim_err_irq", 32'(irq), 32'd1);
    rd_chk("dim_err_c01", el(2, 0, 1), 32'd4);
    rd_chk("dim_err_cycles", OFF + 32'd12, 32'd0);
    wr(OFF + 32'd8, 32'h0002_0202);
    wr(OFF, 32'h0000_0001);
    rd_chk("op_err_status", OFF + 32'd4, 32'd4);
    chk("op_err_irq", 32'(irq), 32'd0);

    load_mul();
    wr(OFF, 32'h0000_0013);
    chk("start_clr_irq", 32'(irq), 32'd0);
    wr(el(0, 0, 0), 32'd9);
    wr(OFF, 32'h0000_0013);
    rd_chk("mid_busy", OFF + 32'd4, 32'd1);
    wait_done();
    check_mul("mid");
    rd_chk("mid_a00_dropped", el(0, 0, 0), 32'd1);
    chk("mid_irq", 32'(irq), 32'd1);

    acks = 0;
    @(posedge clk); #1;
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.addr = OFF + 32'd12;
    repeat (3) begin
      @(posedge clk); #1;
      acks += int'(bus.ack);
    end
    bus.cyc = 1'b0; bus.stb = 1'b0;
    chk("held_acks", 32'(acks), 32'd1);

    wr(OFF, 32'h0000_0013);
    chk("rst_run_irq", 32'(irq), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ack", 32'(bus.ack), 32'd0);
    chk("midrst_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    rd_chk("midrst_status", OFF + 32'd4, 32'd0);
    rd_chk("midrst_c00", el(2, 0, 0), 32'd0);
    rd_chk("midrst_a00", el(0, 0, 0), 32'd0);
    rd_chk("midrst_dim", OFF + 32'd8, 32'd0);
    rd_chk("midrst_ctrl", OFF, 32'd0);
    rd_chk("midrst_cycles", OFF + 32'd12, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
